// File: rtl/adder_arbiter.sv
// Shared adder with round-robin arbitration among NUM_REQ requesters.
// Each accepted request runs IDLE -> EXEC -> DONE and returns one ack pulse.
module adder_arbiter #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 3
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   op_a,
  input  logic [NUM_REQ*WIDTH-1:0]   op_b,
  output logic [NUM_REQ-1:0]         grant,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           result,
  output logic                       carry,
  output logic                       busy
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDXW:0]   NREQ_W = NUM_REQ[IDXW:0];
  localparam logic [IDXW-1:0] LAST   = IDXW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t state, state_nx;

  logic [IDXW-1:0]      rr_ptr, winner, pick, pick_off, rr_next;
  logic [IDXW:0]        pick_sum;
  logic                 found;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [WIDTH-1:0]     lat_a, lat_b, sel_a, sel_b;
  logic [WIDTH:0]       sum_full;
  logic                 load, compute, finish;

  // Rotate req so rr_ptr sits at bit 0; the lowest set bit is then the
  // round-robin winner, offset back by rr_ptr with wrap.
  always_comb begin
    req_dbl  = {req, req};
    req_rot  = NUM_REQ'(req_dbl >> rr_ptr);
    found    = 1'b0;
    pick_off = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && req_rot[k]) begin
        found    = 1'b1;
        pick_off = IDXW'(k);
      end
    end
    pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
    if (pick_sum >= NREQ_W)
      pick_sum = pick_sum - NREQ_W;
    pick = pick_sum[IDXW-1:0];
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick == IDXW'(i)) begin
        sel_a = op_a[i*WIDTH +: WIDTH];
        sel_b = op_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign rr_next  = (winner == LAST) ? '0 : winner + 1'b1;
  assign sum_full = {1'b0, lat_a} + {1'b0, lat_b};
  assign busy     = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    compute  = 1'b0;
    finish   = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          load     = 1'b1;
          state_nx = EXEC;
        end
      end
      EXEC: begin
        compute  = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        finish   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // ack is registered on the EXEC->DONE edge so it is visible exactly during DONE.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr <= '0;
      winner <= '0;
      grant  <= '0;
      ack    <= '0;
      result <= '0;
      carry  <= 1'b0;
      lat_a  <= '0;
      lat_b  <= '0;
    end else begin
      ack <= '0;
      if (load) begin
        winner <= pick;
        grant  <= NUM_REQ'(1) << pick;
        lat_a  <= sel_a;
        lat_b  <= sel_b;
      end
      if (compute) begin
        {carry, result} <= sum_full;
        ack             <= grant;
      end
      if (finish) begin
        rr_ptr <= rr_next;
        grant  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: a transaction-level model predicts each
// ack (requester, sum, carry, cycle); a negedge monitor checks DUT outputs.
module tb_adder_arbiter;

  localparam int W = 32;
  localparam int N = 3;

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*W-1:0]   op_a = '0;
  logic [N*W-1:0]   op_b = '0;
  logic [N-1:0]     grant, ack;
  logic [W-1:0]     result;
  logic             carry, busy;

  adder_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .op_a(op_a), .op_b(op_b),
    .grant(grant), .ack(ack), .result(result), .carry(carry), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [N-1:0] ack;
    logic [W-1:0] res;
    logic         c;
    int           due;
  } exp_t;

  exp_t         sbq[$];
  logic [N-1:0] ack_log[$];
  int           errors = 0;
  int           checks = 0;

  int           cyc = 0;
  int           m_busy = 0;
  int           m_ptr = 0;
  int           m_win = 0;
  logic         m_rst = 1'b1;
  logic [N-1:0] m_grant = '0;
  logic [W-1:0] last_res = '0;
  logic         last_c = 1'b0;
  logic [N-1:0] last_ack = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: an accepted request occupies the adder for 3 cycles,
  // the winner is the first requester at or after the pointer, and the
  // pointer moves past the winner when the adder frees up.
  always @(posedge clock) begin
    cyc++;
    m_rst = !reset_n;
    if (!reset_n) begin
      if (m_busy == 2) sbq.delete(sbq.size() - 1);
      m_busy  = 0;
      m_ptr   = 0;
      m_grant = '0;
    end else if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_ptr   = (m_win + 1) % N;
        m_grant = '0;
      end
    end else if (req != '0) begin
      exp_t e;
      logic [W:0] s;
      for (int k = N - 1; k >= 0; k--)
        if (req[(m_ptr + k) % N]) m_win = (m_ptr + k) % N;
      s     = {1'b0, op_a[m_win*W +: W]} + {1'b0, op_b[m_win*W +: W]};
      e.ack = N'(1) << m_win;
      e.res = s[W-1:0];
      e.c   = s[W];
      e.due = cyc + 1;
      sbq.push_back(e);
      m_busy  = 2;
      m_grant = N'(1) << m_win;
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (m_rst) begin
      check("reset_outputs", {24'd0, grant, ack, busy, carry, result}, 64'd0);
      last_res = '0;
      last_c   = 1'b0;
    end else begin
      check("grant", {61'd0, grant}, {61'd0, m_grant});
      check("busy", {63'd0, busy}, {63'd0, (m_busy > 0)});
      if (ack != '0) begin
        if (sbq.size() == 0) begin
          check("unexpected_ack", {61'd0, ack}, 64'd0);
        end else begin
          e = sbq.pop_front();
          check("ack", {61'd0, ack}, {61'd0, e.ack});
          check("result", {32'd0, result}, {32'd0, e.res});
          check("carry", {63'd0, carry}, {63'd0, e.c});
          check("ack_cycle", 64'(cyc), 64'(e.due));
        end
        last_res = result;
        last_c   = carry;
        last_ack = ack;
        ack_log.push_back(ack);
      end else begin
        check("hold_result", {31'd0, carry, result}, {31'd0, last_c, last_res});
      end
    end
  end

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    req = '0;
    @(negedge clock);
    while ((busy || sbq.size() != 0) && n < 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    check("idle_timeout", {63'd0, (busy || sbq.size() != 0)}, 64'd0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    reset_n = 1'b1;

    // Single request
    ack_log.delete();
    set_ops(0, 32'd4, 32'h0040_0000);
    req = 3'b001;
    @(negedge clock);
    check("single_grant", {61'd0, grant}, 64'd1);
    wait_idle();
    check("single_res", {32'd0, last_res}, 64'h0040_0004);
    check("single_ack", {61'd0, last_ack}, 64'd1);
    check("single_carry", {63'd0, last_c}, 64'd0);

    // Contention from rr_ptr=0
    do_reset();
    ack_log.delete();
    for (int i = 0; i < N; i++) set_ops(i, 32'h1000 * (i + 1) + i, 32'h10 * (i + 1));
    req = 3'b111;
    repeat (10) @(negedge clock);
    wait_idle();
    check("rr_count", 64'(ack_log.size()), 64'd4);
    if (ack_log.size() == 4) begin
      check("rr_order0", {61'd0, ack_log[0]}, 64'd1);
      check("rr_order1", {61'd0, ack_log[1]}, 64'd2);
      check("rr_order2", {61'd0, ack_log[2]}, 64'd4);
      check("rr_order3", {61'd0, ack_log[3]}, 64'd1);
    end

    // Overflow
    do_reset();
    set_ops(1, 32'hFFFF_FFFF, 32'd2);
    req = 3'b010;
    @(negedge clock);
    wait_idle();
    check("ovf_res", {32'd0, last_res}, 64'd1);
    check("ovf_carry", {63'd0, last_c}, 64'd1);
    check("ovf_ack", {61'd0, last_ack}, 64'd2);

    // Operand change in flight
    set_ops(2, 32'd10, 32'd20);
    req = 3'b100;
    @(negedge clock);
    set_ops(2, 32'd99, 32'd20);
    wait_idle();
    check("inflight_res", {32'd0, last_res}, 64'd30);

    // Reset during EXEC
    do_reset();
    ack_log.delete();
    set_ops(0, 32'd7, 32'd8);
    set_ops(1, 32'd100, 32'd200);
    req = 3'b001;
    @(negedge clock);
    check("abort_busy", {63'd0, busy}, 64'd1);
    reset_n = 1'b0;
    req = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    req = 3'b010;
    @(negedge clock);
    check("post_reset_grant", {61'd0, grant}, 64'd2);
    wait_idle();
    check("abort_acks", 64'(ack_log.size()), 64'd1);
    check("abort_res", {32'd0, last_res}, 64'd300);

    // Drop request during EXEC
    ack_log.delete();
    set_ops(1, 32'd5, 32'd6);
    req = 3'b010;
    @(negedge clock);
    req = '0;
    wait_idle();
    check("drop_acks", 64'(ack_log.size()), 64'd1);
    check("drop_ack", {61'd0, last_ack}, 64'd2);
    check("drop_busy", {63'd0, busy}, 64'd0);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      req = N'($urandom_range(0, 7));
      for (int i = 0; i < N; i++)
        set_ops(i, ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom(), $urandom());
      reset_n = ($urandom_range(0, 99) != 0);
      @(negedge clock);
    end
    reset_n = 1'b1;
    wait_idle();
    check("queue_empty", 64'(sbq.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
